// File: rtl/pkt_tx_buffer.sv
// Store-and-forward transmit packet buffer.
// Whole packets are admitted or dropped on the input side. Only committed packets are
// released to the egress port under a valid/ready handshake.
// Optional statistics outputs are enabled by defining PKT_TX_BUF_STATS_EN.
module pkt_tx_buffer #(
    parameter int unsigned DEPTH_LOG2    = 8,
    parameter int unsigned MAX_PKT_FLITS = 97
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_pkt_valid,
    input  logic [133:0]        i_pkt,
    output logic                o_pkt_valid,
    output logic [133:0]        o_pkt,
    input  logic                i_ready,
    output logic [DEPTH_LOG2:0] o_pkt_cnt,
    output logic                o_drop_pulse
`ifdef PKT_TX_BUF_STATS_EN
    ,
    output logic [31:0]         o_stat_pkt_in,
    output logic [31:0]         o_stat_pkt_drop,
    output logic [DEPTH_LOG2:0] o_stat_max_fill
`endif
);

    typedef logic [DEPTH_LOG2:0] ptr_t;

    localparam ptr_t DEPTH_FLITS = ptr_t'(2 ** DEPTH_LOG2);
    localparam ptr_t MAX_FLITS   = ptr_t'(MAX_PKT_FLITS);
    localparam ptr_t PTR_ONE     = ptr_t'(1);

    typedef enum logic [1:0] {StIdle, StWrite, StDrop} wr_state_e;

    wr_state_e state_q, state_d;
    ptr_t      wr_ptr_q, wr_ptr_d;
    ptr_t      cm_ptr_q, cm_ptr_d;
    ptr_t      rd_ptr_q;
    ptr_t      wr_addr;
    logic      wr_en;
    logic      drop;
    logic      commit;

    logic [133:0] mem [2 ** DEPTH_LOG2];

    logic         pkt_valid_q;
    logic [133:0] pkt_q;
    ptr_t         pkt_cnt_q;
    logic         drop_pulse_q;

    logic is_head, is_body, is_tail;
    ptr_t fill, free_cm;
    logic full, head_admit;
    logic rd_load, tail_out;

    assign is_head = i_pkt_valid && (i_pkt[133:132] == 2'b01);
    assign is_body = i_pkt_valid && (i_pkt[133:132] == 2'b11);
    assign is_tail = i_pkt_valid && (i_pkt[133:132] == 2'b10);

    assign fill       = wr_ptr_q - rd_ptr_q;
    // A new head always starts from the committed pointer, whatever was in flight.
    assign free_cm    = DEPTH_FLITS - (cm_ptr_q - rd_ptr_q);
    assign full       = (fill == DEPTH_FLITS);
    assign head_admit = (free_cm >= MAX_FLITS);

    // Write FSM next-state: admission, commit, rollback and drop decisions.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cm_ptr_d = cm_ptr_q;
        wr_en    = 1'b0;
        wr_addr  = wr_ptr_q;
        drop     = 1'b0;
        commit   = 1'b0;
        if (is_head) begin
            // Head in WRITE truncates the open packet; every state then treats it as fresh.
            if (state_q == StWrite) begin
                drop = 1'b1;
            end
            wr_ptr_d = cm_ptr_q;
            if (head_admit) begin
                wr_en    = 1'b1;
                wr_addr  = cm_ptr_q;
                wr_ptr_d = cm_ptr_q + PTR_ONE;
                state_d  = StWrite;
            end else begin
                drop    = 1'b1;
                state_d = StDrop;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (is_body || is_tail) begin
                        drop = 1'b1;
                    end
                end
                StWrite: begin
                    if (is_body || is_tail) begin
                        if (full) begin
                            // Oversize packet: discard it; a tail here already ends it.
                            wr_ptr_d = cm_ptr_q;
                            drop     = 1'b1;
                            state_d  = is_tail ? StIdle : StDrop;
                        end else begin
                            wr_en    = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                            if (is_tail) begin
                                cm_ptr_d = wr_ptr_q + PTR_ONE;
                                commit   = 1'b1;
                                state_d  = StIdle;
                            end
                        end
                    end
                end
                StDrop: begin
                    if (is_tail) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Write FSM state and pointer registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            cm_ptr_q     <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            cm_ptr_q     <= cm_ptr_d;
            drop_pulse_q <= drop;
        end
    end

    // Flit storage; no reset needed since only committed entries are ever read.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr[DEPTH_LOG2-1:0]] <= i_pkt;
        end
    end

    assign rd_load  = (rd_ptr_q != cm_ptr_q) && (!pkt_valid_q || i_ready);
    assign tail_out = pkt_valid_q && i_ready && (pkt_q[133:132] == 2'b10);

    // Output register: refill from committed flits, hold while egress stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr_q    <= '0;
            pkt_valid_q <= 1'b0;
            pkt_q       <= '0;
        end else if (rd_load) begin
            pkt_q       <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
            pkt_valid_q <= 1'b1;
            rd_ptr_q    <= rd_ptr_q + PTR_ONE;
        end else if (i_ready) begin
            pkt_valid_q <= 1'b0;
        end
    end

    // Stored complete-packet count: up on commit, down on tail handshake.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pkt_cnt_q <= '0;
        end else if (commit && !tail_out) begin
            pkt_cnt_q <= pkt_cnt_q + PTR_ONE;
        end else if (!commit && tail_out) begin
            pkt_cnt_q <= pkt_cnt_q - PTR_ONE;
        end
    end

    assign o_pkt_valid  = pkt_valid_q;
    assign o_pkt        = pkt_q;
    assign o_pkt_cnt    = pkt_cnt_q;
    assign o_drop_pulse = drop_pulse_q;

`ifdef PKT_TX_BUF_STATS_EN
    logic [31:0] stat_in_q, stat_drop_q;
    ptr_t        stat_fill_q;

    // Saturating packet counters and fill high-water mark.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stat_in_q   <= '0;
            stat_drop_q <= '0;
            stat_fill_q <= '0;
        end else begin
            if (commit && (stat_in_q != '1)) begin
                stat_in_q <= stat_in_q + 32'd1;
            end
            if (drop && (stat_drop_q != '1)) begin
                stat_drop_q <= stat_drop_q + 32'd1;
            end
            if (fill > stat_fill_q) begin
                stat_fill_q <= fill;
            end
        end
    end

    assign o_stat_pkt_in   = stat_in_q;
    assign o_stat_pkt_drop = stat_drop_q;
    assign o_stat_max_fill = stat_fill_q;
`endif

endmodule

// File: tb/tb_pkt_tx_buffer.sv
// Scoreboard bench for pkt_tx_buffer: a packet-level reference model fills an expected
// flit queue as stimulus is issued; a monitor pops and compares on every output handshake.
module tb_pkt_tx_buffer;

    localparam int DEPTH = 256;
    localparam int MAXF  = 97;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_pkt_valid = 1'b0;
    logic [133:0] i_pkt = '0;
    logic         i_ready = 1'b0;
    logic         o_pkt_valid;
    logic [133:0] o_pkt;
    logic [8:0]   o_pkt_cnt;
    logic         o_drop_pulse;
`ifdef PKT_TX_BUF_STATS_EN
    logic [31:0]  o_stat_pkt_in;
    logic [31:0]  o_stat_pkt_drop;
    logic [8:0]   o_stat_max_fill;
`endif

    pkt_tx_buffer #(
        .DEPTH_LOG2   (8),
        .MAX_PKT_FLITS(MAXF)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_pkt_valid    (i_pkt_valid),
        .i_pkt          (i_pkt),
        .o_pkt_valid    (o_pkt_valid),
        .o_pkt          (o_pkt),
        .i_ready        (i_ready),
        .o_pkt_cnt      (o_pkt_cnt),
        .o_drop_pulse   (o_drop_pulse)
`ifdef PKT_TX_BUF_STATS_EN
        ,
        .o_stat_pkt_in  (o_stat_pkt_in),
        .o_stat_pkt_drop(o_stat_pkt_drop),
        .o_stat_max_fill(o_stat_max_fill)
`endif
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_flit(input string name, input logic [133:0] act,
                              input logic [133:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: packets are assembled in part_q and released whole into exp_q.
    typedef enum int {MIdle, MAcc, MDiscard} mst_e;
    mst_e         mst = MIdle;
    logic [133:0] exp_q[$];
    logic [133:0] part_q[$];
    int n_written = 0;  // flits accepted into the buffer (incl. partial, minus rollbacks)
    int n_popped  = 0;  // flits handshaked out
    int exp_drops = 0;
    int exp_pkts  = 0;
    int seen_drops = 0;

    function automatic int occ();
        return n_written - n_popped;
    endfunction

    function automatic void model_flit(input logic [133:0] f);
        logic [1:0] t;
        t = f[133:132];
        if (t == 2'b01) begin
            if (mst == MAcc) begin
                exp_drops++;
                n_written -= part_q.size();
                part_q.delete();
            end
            if (DEPTH - occ() >= MAXF) begin
                part_q.push_back(f);
                n_written++;
                mst = MAcc;
            end else begin
                exp_drops++;
                mst = MDiscard;
            end
        end else if (t == 2'b11 || t == 2'b10) begin
            case (mst)
                MIdle: exp_drops++;
                MAcc: begin
                    if (occ() >= DEPTH) begin
                        exp_drops++;
                        n_written -= part_q.size();
                        part_q.delete();
                        mst = (t == 2'b10) ? MIdle : MDiscard;
                    end else begin
                        part_q.push_back(f);
                        n_written++;
                        if (t == 2'b10) begin
                            foreach (part_q[i]) exp_q.push_back(part_q[i]);
                            part_q.delete();
                            exp_pkts++;
                            mst = MIdle;
                        end
                    end
                end
                default: if (t == 2'b10) mst = MIdle;
            endcase
        end
    endfunction

    function automatic logic [133:0] mk(input logic [1:0] t);
        logic [3:0] inv;
        inv = (t == 2'b10) ? 4'($urandom_range(0, 15)) : 4'h0;
        return {t, inv, $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    int rmode = 0;  // 0: ready low, 1: ready high, 2: random ready

    task automatic tick(input bit v, input logic [133:0] f);
        @(posedge i_clk);
        #1;
        i_pkt_valid = v;
        i_pkt = f;
        case (rmode)
            0: i_ready = 1'b0;
            1: i_ready = 1'b1;
            default: i_ready = ($urandom_range(0, 99) < 70);
        endcase
        if (v) model_flit(f);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, '0);
    endtask

    task automatic send_pkt(input int len, input int gap_pct);
        tick(1'b1, mk(2'b01));
        for (int i = 0; i < len - 1; i++) begin
            while ($urandom_range(0, 99) < gap_pct) idle(1);
            tick(1'b1, mk((i == len - 2) ? 2'b10 : 2'b11));
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        rmode = 1;
        while ((exp_q.size() != 0 || o_pkt_valid) && n < 3000) begin
            idle(1);
            n++;
        end
        idle(2);
        check_int({name, "_drained"}, int'(n < 3000), 1);
    endtask

    task automatic check_drops(input string name);
        idle(3);
        check_int(name, seen_drops, exp_drops);
    endtask

    // Monitor: scoreboard pop on handshake, hold stability while stalled, drop pulses.
    logic [133:0] held = '0;
    bit           hold_chk = 1'b0;
    always @(negedge i_clk) begin
        if (i_rst) begin
            hold_chk = 1'b0;
        end else begin
            if (o_drop_pulse) seen_drops++;
            if (hold_chk) begin
                check_int("hold_valid", int'(o_pkt_valid), 1);
                check_flit("hold_data", o_pkt, held);
            end
            if (o_pkt_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_flit: got %h expected no flit", o_pkt);
                end else begin
                    check_flit("out_flit", o_pkt, exp_q.pop_front());
                    n_popped++;
                end
            end
            hold_chk = o_pkt_valid && !i_ready;
            held = o_pkt;
        end
    end

    initial begin
        int t_tail;
        int n;
        int r;
        logic [133:0] h0;

        repeat (3) @(posedge i_clk);
        #1;
        check_int("rst_valid", int'(o_pkt_valid), 0);
        check_int("rst_cnt", int'(o_pkt_cnt), 0);
        check_int("rst_drop", int'(o_drop_pulse), 0);
        i_rst = 1'b0;

        // Single 4-flit packet, latency and count
        rmode = 1;
        tick(1'b1, mk(2'b01));
        tick(1'b1, mk(2'b11));
        tick(1'b1, mk(2'b11));
        tick(1'b1, mk(2'b10));
        t_tail = cyc;
        check_int("t1_cnt_before", int'(o_pkt_cnt), 0);
        idle(1);
        check_int("t1_cnt_commit", int'(o_pkt_cnt), 1);
        n = 0;
        while (!o_pkt_valid && n < 10) begin
            idle(1);
            n++;
        end
        check_int("t1_latency", cyc - t_tail, 2);
        drain("t1");
        check_int("t1_cnt_end", int'(o_pkt_cnt), 0);

        // Three packets stored while stalled, then released
        rmode = 0;
        h0 = mk(2'b01);
        tick(1'b1, h0);
        tick(1'b1, mk(2'b11));
        tick(1'b1, mk(2'b11));
        tick(1'b1, mk(2'b10));
        send_pkt(4, 0);
        send_pkt(4, 0);
        idle(4);
        check_int("t2_cnt3", int'(o_pkt_cnt), 3);
        check_int("t2_valid", int'(o_pkt_valid), 1);
        check_flit("t2_head_held", o_pkt, h0);
        drain("t2");
        check_int("t2_cnt_end", int'(o_pkt_cnt), 0);

        // Truncated packet followed by a good one
        rmode = 1;
        tick(1'b1, mk(2'b01));
        tick(1'b1, mk(2'b11));
        send_pkt(4, 0);
        check_drops("t3_drops");
        drain("t3");

        // Fill to 200 flits, then a packet that cannot be admitted
        rmode = 0;
        send_pkt(97, 0);
        send_pkt(62, 0);
        send_pkt(41, 0);
        idle(2);
        check_int("t4_cnt3", int'(o_pkt_cnt), 3);
        send_pkt(3, 0);
        check_drops("t4_drops");
        check_int("t4_cnt_unchanged", int'(o_pkt_cnt), 3);
        drain("t4a");
        send_pkt(5, 0);
        drain("t4b");
        check_int("t4_cnt_end", int'(o_pkt_cnt), 0);

        // Orphan body flit
        rmode = 1;
        tick(1'b1, mk(2'b11));
        check_drops("t5_drops");
        check_int("t5_no_output", int'(o_pkt_valid), 0);

        // Oversize packet overflows the buffer
        rmode = 0;
        send_pkt(260, 0);
        check_drops("t6_drops");
        check_int("t6_cnt", int'(o_pkt_cnt), 0);
        check_int("t6_no_output", int'(o_pkt_valid), 0);
        rmode = 1;
        send_pkt(4, 0);
        drain("t6");

        // Randomized traffic with truncations and orphans
        rmode = 2;
        for (int p = 0; p < 80; p++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                tick(1'b1, mk(2'b11));
            end else begin
                n = 0;
                while (DEPTH - occ() < MAXF && n < 1000) begin
                    idle(1);
                    n++;
                end
                check_int("rand_throttle", int'(n < 1000), 1);
                if (r < 15) begin
                    tick(1'b1, mk(2'b01));
                    repeat ($urandom_range(0, 3)) tick(1'b1, mk(2'b11));
                end
                send_pkt($urandom_range(2, 10), 20);
                idle($urandom_range(0, 2));
            end
        end
        drain("rand");
        check_drops("rand_drops");
        check_int("rand_cnt_end", int'(o_pkt_cnt), 0);

        // Reset in the middle of a packet with two packets stored
        rmode = 0;
        send_pkt(4, 0);
        send_pkt(4, 0);
        tick(1'b1, mk(2'b01));
        repeat (4) tick(1'b1, mk(2'b11));
`ifdef PKT_TX_BUF_STATS_EN
        check_int("stat_in", int'(o_stat_pkt_in), exp_pkts);
        check_int("stat_drop", int'(o_stat_pkt_drop), exp_drops);
        check_int("stat_max_fill", int'(o_stat_max_fill), DEPTH);
`endif
        #2;
        i_rst = 1'b1;
        i_pkt_valid = 1'b0;
        #1;
        check_int("t8_valid", int'(o_pkt_valid), 0);
        check_int("t8_cnt", int'(o_pkt_cnt), 0);
        check_int("t8_drop", int'(o_drop_pulse), 0);
`ifdef PKT_TX_BUF_STATS_EN
        check_int("t8_stat_in", int'(o_stat_pkt_in), 0);
        check_int("t8_stat_drop", int'(o_stat_pkt_drop), 0);
        check_int("t8_stat_fill", int'(o_stat_max_fill), 0);
`endif
        exp_q.delete();
        part_q.delete();
        mst = MIdle;
        n_written = 0;
        n_popped = 0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        rmode = 1;
        send_pkt(4, 0);
        drain("t8");
        check_int("t8_cnt_end", int'(o_pkt_cnt), 0);
        check_drops("final_drops");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pkt_tx_buffer.md
Name: pkt_tx_buffer

Overview:
- Store-and-forward packet FIFO directly downstream of the MAC-rewrite stage.
- Accepts 134-bit flits with no backpressure on the input side; drops whole packets that cannot fit.
- Releases only complete packets to the transmit side under a valid/ready handshake.
- Decouples the free-running parser pipeline from a stallable egress port.

Parameters:
- DEPTH_LOG2, 8, log2 of buffer depth in flits (256).
- MAX_PKT_FLITS, 97, largest legal packet in flits; admission threshold.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  asynchronous active-high reset.
- i_pkt_valid  input  1  input flit valid; no backpressure.
- i_pkt  input  134  input flit. [133:132]: 01=head, 11=body, 10=tail. [131:128]: invalid-byte count (tail only). [127:0]: data.
- o_pkt_valid  output  1  output flit valid.
- o_pkt  output  134  output flit, same format as i_pkt.
- i_ready  input  1  egress accepts o_pkt this cycle.
- o_pkt_cnt  output  DEPTH_LOG2+1  number of complete packets stored.
- o_drop_pulse  output  1  one-cycle pulse per dropped packet.

Behaviour:
- Interface: one clock (i_clk), asynchronous active-high reset (i_rst).
- Reset: all outputs 0, both pointers 0, write FSM in IDLE. Reset mid-packet discards everything, including partial packets.
- Storage: dual-pointer RAM. wr_ptr is the tentative pointer, cm_ptr the committed pointer, rd_ptr the read pointer; all DEPTH_LOG2+1 bits, wrap modulo 2^(DEPTH_LOG2+1). free = 2^DEPTH_LOG2 - (wr_ptr - rd_ptr).
- Write FSM states: IDLE, WRITE, DROP.
- IDLE + head flit:
  - free >= MAX_PKT_FLITS: write the flit, go to WRITE.
  - otherwise: go to DROP.
  - Body or tail flit in IDLE: ignore, pulse o_drop_pulse once, stay in IDLE.
- WRITE:
  - Body flit: write it.
  - Tail flit: write it, set cm_ptr <= wr_ptr+1 that cycle, go to IDLE.
  - Head flit (truncated packet): rollback wr_ptr <= cm_ptr, pulse o_drop_pulse, then re-evaluate the new head as if in IDLE in the same cycle.
  - Full buffer (wr_ptr-rd_ptr = 2^DEPTH_LOG2) before tail (oversize packet): rollback, pulse o_drop_pulse, go to DROP.
- DROP: discard flits until a tail is seen, then go to IDLE. o_drop_pulse fires once, on entry to DROP. A head flit in DROP is handled as in IDLE.
- o_pkt_cnt:
  - +1 on commit; -1 when a tail flit handshakes on the output (o_pkt_valid & i_ready & o_pkt[133:132]==10).
  - Simultaneous commit and output tail: unchanged.
  - Never wraps; bounded by depth.
- Read side:
  - o_pkt/o_pkt_valid are registered.
  - Load the next flit when (rd_ptr != cm_ptr) and (o_pkt_valid==0 or i_ready==1).
  - o_pkt_valid drops when no committed flit remains.
  - Flits of an uncommitted packet are never read.
  - Held flit stays stable while o_pkt_valid & ~i_ready.
- Latency: tail written at cycle T → head flit on o_pkt at T+2 when the buffer was empty. Sustained throughput is 1 flit/cycle with i_ready=1.
- Rollback never touches rd_ptr or o_pkt.

Optional Feature:
- Macro PKT_TX_BUF_STATS_EN.
- Defined: adds outputs o_stat_pkt_in[31:0] (committed packets), o_stat_pkt_drop[31:0] (o_drop_pulse events) and o_stat_max_fill[DEPTH_LOG2:0] (high-water mark of wr_ptr-rd_ptr). Counters saturate at all-ones and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- 4-flit packet (01,11,11,10), i_ready=1 → o_pkt_cnt 0→1→0; head on o_pkt 2 cycles after tail input; 4 consecutive valid flits identical to input.
- Three 4-flit packets back-to-back, i_ready=0 → o_pkt_cnt=3, o_pkt_valid=1 holding the first head stable. Release i_ready → 12 flits in order, o_pkt_cnt ends at 0.
- Head,body then new head (truncation) → one o_drop_pulse; only the second packet emerges; committed data unaffected.
- Fill to 200 flits with i_ready=0 (free=56 < 97), send a 3-flit packet → dropped, o_drop_pulse=1, o_pkt_cnt unchanged. Next packet after draining is accepted.
- Orphan body flit in IDLE → ignored, one o_drop_pulse, no output.
- Assert i_rst during a 10-flit packet with 2 packets stored → o_pkt_valid=0, o_pkt_cnt=0 immediately; next clean packet passes. With PKT_TX_BUF_STATS_EN, all stats read 0 after reset.
